// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: data width, register map and status-word layout.
// Bits are numbered big-endian ([0:63]), so bit 63 is the LSB and bit 0 the MSB.
package cardinal_nic_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] NIC_IN_DATA  = 2'b00;
    localparam logic [1:0] NIC_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_OUT_DATA = 2'b10;
    localparam logic [1:0] NIC_OUT_STAT = 2'b11;

    localparam int FULL_BIT = 63;
    localparam int VC_BIT   = 0;

    function automatic logic [0:DATA_W-1] status_word(input logic full);
        logic [0:DATA_W-1] w;
        w           = {DATA_W{1'b0}};
        w[FULL_BIT] = full;
        return w;
    endfunction

endpackage

// File: rtl/cardinal_nic_buf.sv
// One-entry packet buffer with a full flag; load wins over clear (the top never asserts both).
module cardinal_nic_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [0:W-1] din,
    output logic [0:W-1] data,
    output logic         full
);
    import cardinal_nic_pkg::*;

    logic [0:W-1] data_d, data_q;
    logic         full_d, full_q;

    // Next-state for the buffer contents and its occupancy flag.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load) begin
            data_d = din;
            full_d = 1'b1;
        end else if (clr) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // State register; reset flushes the packet immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= {W{1'b0}};
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign full = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC top: processor register decode, load mux and router send/receive gating.
// Optional feature macro: CARDINAL_NIC_POLARITY_EN (gates injection on the router polarity).
module cardinal_nic #(
    parameter int DATA_W = cardinal_nic_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_polarity
);
    import cardinal_nic_pkg::*;

    logic              rd_s, wr_s;
    logic              in_load_s, in_clr_s, in_full_s;
    logic              out_load_s, out_clr_s, out_full_s;
    logic [0:DATA_W-1] in_data_s, out_data_s;
    logic              match_s, send_s;

    assign rd_s = nicEn & ~nicWrEn;
    assign wr_s = nicEn & nicWrEn;

    // A load of 00 only frees the buffer when it actually holds a packet.
    assign in_load_s  = net_si & ~in_full_s;
    assign in_clr_s   = rd_s & (addr == NIC_IN_DATA) & in_full_s;
    assign out_load_s = wr_s & (addr == NIC_OUT_DATA) & ~out_full_s;
    assign out_clr_s  = send_s;

`ifdef CARDINAL_NIC_POLARITY_EN
    assign match_s = (out_data_s[VC_BIT] == net_polarity);
`else
    assign match_s = net_polarity | 1'b1;
`endif

    assign send_s = out_full_s & net_ro & match_s;

    cardinal_nic_buf #(.W(DATA_W)) u_in_buf (
        .clk   (clk),
        .reset (reset),
        .load  (in_load_s),
        .clr   (in_clr_s),
        .din   (net_di),
        .data  (in_data_s),
        .full  (in_full_s)
    );

    cardinal_nic_buf #(.W(DATA_W)) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .load  (out_load_s),
        .clr   (out_clr_s),
        .din   (d_in),
        .data  (out_data_s),
        .full  (out_full_s)
    );

    // Processor load mux; the output buffer is store-only and reads back as zero.
    always_comb begin
        d_out = {DATA_W{1'b0}};
        if (rd_s) begin
            case (addr)
                NIC_IN_DATA:  d_out = in_data_s;
                NIC_IN_STAT:  d_out = status_word(in_full_s);
                NIC_OUT_STAT: d_out = status_word(out_full_s);
                default:      d_out = {DATA_W{1'b0}};
            endcase
        end else begin
            d_out = {DATA_W{1'b0}};
        end
    end

    assign net_ri = ~in_full_s;
    assign net_so = send_s;
    assign net_do = out_data_s;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic; inputs change on negedge, outputs sampled 1ns later.
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in, d_out, net_di, net_do;
    logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

    int n_cmp = 0;
    int n_err = 0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Move to the next cycle and drive a processor access (en=0 means idle).
    task automatic cyc(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d);
        @(negedge clk);
        nicEn   = en;
        nicWrEn = wr;
        addr    = a;
        d_in    = d;
        #1;
    endtask

    initial begin
        reset = 1'b0; addr = 2'b00; d_in = 64'h0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = 64'h0; net_ro = 1'b0; net_polarity = 1'b0;
        #1;
        check_val("rst_ri", 64'(net_ri), 64'h1);
        check_val("rst_so", 64'(net_so), 64'h0);
        check_val("rst_do", net_do, 64'h0);
        check_val("rst_dout", d_out, 64'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Status reads after reset
        cyc(1'b1, 1'b0, 2'b01, 64'h0);
        check_val("in_stat0", d_out, 64'h0);
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("out_stat0", d_out, 64'h0);
        check_val("ri0", 64'(net_ri), 64'h1);
        check_val("so0", 64'(net_so), 64'h0);

        // Store with router stalled for 5 cycles
        cyc(1'b1, 1'b1, 2'b10, 64'h0000_0000_DEAD_BEEF);
        check_val("st_same_cyc_so", 64'(net_so), 64'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 2'b00, 64'h0);
            check_val("stall_so", 64'(net_so), 64'h0);
        end
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("stall_stat", d_out, 64'h1);
        net_ro = 1'b1;
        #1;
        check_val("send_so", 64'(net_so), 64'h1);
        check_val("send_do", net_do, 64'h0000_0000_DEAD_BEEF);
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("sent_so", 64'(net_so), 64'h0);
        check_val("sent_stat", d_out, 64'h0);

        // Minimum store-to-send latency with router ready
        cyc(1'b1, 1'b1, 2'b10, 64'h0000_0000_0000_0042);
        check_val("lat_st_so", 64'(net_so), 64'h0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
        check_val("lat_so", 64'(net_so), 64'h1);
        check_val("lat_do", net_do, 64'h42);
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
        check_val("lat_once", 64'(net_so), 64'h0);

        // VC bit vs polarity
        cyc(1'b1, 1'b1, 2'b10, 64'h8000_0000_0000_0001);
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
`ifdef CARDINAL_NIC_POLARITY_EN
        check_val("vc_mismatch_so", 64'(net_so), 64'h0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
        check_val("vc_hold_so", 64'(net_so), 64'h0);
        net_polarity = 1'b1;
        #1;
`endif
        check_val("vc_send_so", 64'(net_so), 64'h1);
        check_val("vc_send_do", net_do, 64'h8000_0000_0000_0001);
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("vc_done_stat", d_out, 64'h0);
        net_polarity = 1'b0;

        // Router input path
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
        check_val("in_ri_pre", 64'(net_ri), 64'h1);
        net_si = 1'b1; net_di = 64'h1234;
        cyc(1'b1, 1'b0, 2'b01, 64'h0);
        net_di = 64'h5555;
        #1;
        check_val("in_ri_full", 64'(net_ri), 64'h0);
        check_val("in_stat_full", d_out, 64'h1);
        cyc(1'b1, 1'b0, 2'b00, 64'h0);
        check_val("in_data", d_out, 64'h1234);
        check_val("in_ri_rd", 64'(net_ri), 64'h0);
        net_si = 1'b0;
        cyc(1'b1, 1'b0, 2'b01, 64'h0);
        check_val("in_ri_free", 64'(net_ri), 64'h1);
        check_val("in_stat_free", d_out, 64'h0);
        cyc(1'b1, 1'b0, 2'b00, 64'h0);
        check_val("in_stale", d_out, 64'h1234);
        cyc(1'b1, 1'b0, 2'b01, 64'h0);
        check_val("in_stale_stat", d_out, 64'h0);

        // Store while full is dropped, including during a send
        net_ro = 1'b0;
        cyc(1'b1, 1'b1, 2'b10, 64'h5);
        cyc(1'b1, 1'b1, 2'b10, 64'hA);
        cyc(1'b1, 1'b1, 2'b00, 64'h7);
        check_val("drop_do", net_do, 64'h5);
        cyc(1'b1, 1'b1, 2'b10, 64'hB);
        net_ro = 1'b1;
        #1;
        check_val("drop_send_so", 64'(net_so), 64'h1);
        check_val("drop_send_do", net_do, 64'h5);
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("drop_after_so", 64'(net_so), 64'h0);
        check_val("drop_after_stat", d_out, 64'h0);

        // Asynchronous reset with both buffers full
        net_ro = 1'b0;
        net_si = 1'b1; net_di = 64'h77;
        cyc(1'b1, 1'b1, 2'b10, 64'h99);
        net_si = 1'b0;
        cyc(1'b0, 1'b0, 2'b00, 64'h0);
        check_val("pre_rst_ri", 64'(net_ri), 64'h0);
        net_ro = 1'b1;
        #1;
        check_val("pre_rst_so", 64'(net_so), 64'h1);
        reset = 1'b0;
        #1;
        check_val("arst_so", 64'(net_so), 64'h0);
        check_val("arst_ri", 64'(net_ri), 64'h1);
        check_val("arst_do", net_do, 64'h0);
        @(negedge clk);
        reset = 1'b1; net_ro = 1'b0;
        cyc(1'b1, 1'b0, 2'b01, 64'h0);
        check_val("post_rst_in", d_out, 64'h0);
        cyc(1'b1, 1'b0, 2'b11, 64'h0);
        check_val("post_rst_out", d_out, 64'h0);
        cyc(1'b0, 1'b0, 2'b00, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
